div4_seq: RTL and testbench



---
 rtl/div4_seq_pkg.sv | 14 +
 rtl/div4_seq_sub4_ov.sv | 33 +++
 rtl/div4_seq.sv | 150 +++++++++++++++
 tb/tb_div4_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div4_seq_pkg.sv
// Shared constants and state encoding for the 4-bit sequential restoring divider.
// Optional divide-by-zero shortcut is enabled by defining DIV4_DBZ_EN.
package div4_seq_pkg;

    localparam int WIDTH = 4;
    localparam int ITERS = 4;
    localparam int CNT_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/div4_seq_sub4_ov.sv
// 4-bit subtractor a - b computed as a + ~b + 1 on a carry-lookahead path.
// borrow is the inverted carry-out; the caller folds in any fifth operand bit.
module sub4_ov
    import div4_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign b_n = ~b;
    assign g   = a & b_n;
    assign p   = a ^ b_n;

    // Carry-in of 1 completes the two's complement of b.
    assign c[0] = 1'b1;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign diff   = p ^ c[WIDTH-1:0];
    assign borrow = ~c[WIDTH];

endmodule

// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIV4_DBZ_EN to finish divide-by-zero in one cycle and raise dbz.
module div4_seq
    import div4_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   pr_shift;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;
    logic             borrow5;
    logic             dbz_hit;

`ifdef DIV4_DBZ_EN
    logic dbz_q, dbz_d;
    assign dbz_hit = (dvs_q == '0);
`else
    assign dbz_hit = 1'b0;
`endif

    assign pr_shift = {pr_q[WIDTH-1:0], dvd_q[cnt_q]};

    sub4_ov u_sub (
        .a      (pr_shift[WIDTH-1:0]),
        .b      (dvs_q),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // A set fifth bit means the shifted remainder already exceeds any 4-bit divisor.
    assign borrow5 = sub_borrow & ~pr_shift[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
`ifdef DIV4_DBZ_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    pr_d    = '0;
                    quot_d  = '0;
                    cnt_d   = CNT_W'(ITERS - 1);
                    state_d = RUN;
`ifdef DIV4_DBZ_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (dbz_hit) begin
                    q_d     = '1;
                    r_d     = dvd_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef DIV4_DBZ_EN
                    dbz_d   = 1'b1;
`endif
                end else begin
                    if (borrow5) begin
                        pr_d = pr_shift;
                    end else begin
                        pr_d = {1'b0, sub_diff};
                    end
                    quot_d[cnt_q] = ~borrow5;
                    if (cnt_q == '0) begin
                        q_d     = quot_d;
                        r_d     = pr_d[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
`ifdef DIV4_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
`ifdef DIV4_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
`ifdef DIV4_DBZ_EN
    assign dbz  = dbz_q;
`else
    assign dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_div4_seq.sv
// Directed bench for div4_seq: integer-division reference model checked every cycle,
// plus hand-computed literal checks for the listed scenarios.
module tb_div4_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;

`ifdef DIV4_DBZ_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    div4_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .dbz      (dbz)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: expected results queued at accept, released after the latency
    logic [8:0] exp_q[$];
    bit         model_live = 1'b0;
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [3:0] m_q = '0;
    logic [3:0] m_r = '0;
    logic       m_dbz = 1'b0;

    always @(posedge clk) begin
        logic [8:0] res;
        model_live = 1'b1;
        if (!reset_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dbz  = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    res = exp_q.pop_front();
                    {m_dbz, m_q, m_r} = res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (divisor == 4'd0) begin
                    res = {DBZ_EN, 4'hF, dividend};
                end else begin
                    res = {1'b0, 4'(dividend / divisor), 4'(dividend % divisor)};
                end
                exp_q.push_back(res);
                m_left = (DBZ_EN && divisor == 4'd0) ? 1 : 4;
                if (DBZ_EN) m_dbz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("busy", 8'(busy), 8'(m_left > 0));
            check("done", 8'(done), 8'(m_done));
            check("q", 8'(q), 8'(m_q));
            check("r", 8'(r), 8'(m_r));
            check("dbz", 8'(dbz), 8'(m_dbz));
        end
    end

    // driver tasks
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles at %0t", max, $time);
        end
    endtask

    initial begin
        int lat;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_q", 8'(q), 8'd0);
        check("rst_r", 8'(r), 8'd0);
        check("rst_dbz", 8'(dbz), 8'd0);
        reset_n = 1'b1;

        // 13/3 single pulse
        start_op(4'd13, 4'd3);
        wait_done(10, lat);
        check("lat_13_3", 8'(lat), 8'd4);
        check("q_13_3", 8'(q), 8'd4);
        check("r_13_3", 8'(r), 8'd1);
        @(negedge clk);
        check("done_one_cycle", 8'(done), 8'd0);

        // 15/1 then 2/7 back to back with start held
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
        @(negedge clk);
        dividend = 4'd2;
        divisor  = 4'd7;
        wait_done(10, lat);
        check("q_15_1", 8'(q), 8'd15);
        check("r_15_1", 8'(r), 8'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 8'(busy), 8'd1);
        wait_done(10, lat);
        check("lat_2_7", 8'(lat), 8'd4);
        check("q_2_7", 8'(q), 8'd0);
        check("r_2_7", 8'(r), 8'd2);

        // 9/0
        start_op(4'd9, 4'd0);
        wait_done(10, lat);
`ifdef DIV4_DBZ_EN
        check("lat_9_0", 8'(lat), 8'd1);
        check("dbz_9_0", 8'(dbz), 8'd1);
`else
        check("lat_9_0", 8'(lat), 8'd4);
        check("dbz_9_0", 8'(dbz), 8'd0);
`endif
        check("q_9_0", 8'(q), 8'hF);
        check("r_9_0", 8'(r), 8'd9);

        // start with new operands while busy is ignored
        start_op(4'd14, 4'd4);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, lat);
        check("q_14_4", 8'(q), 8'd3);
        check("r_14_4", 8'(r), 8'd2);

        // reset during the second RUN cycle abandons the operation
        start_op(4'd11, 4'd2);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 8'(busy), 8'd0);
        check("mid_rst_done", 8'(done), 8'd0);
        check("mid_rst_q", 8'(q), 8'd0);
        check("mid_rst_r", 8'(r), 8'd0);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_done_after_rst", 8'(done), 8'd0);
        end
        start_op(4'd7, 4'd2);
        wait_done(10, lat);
        check("q_7_2", 8'(q), 8'd3);
        check("r_7_2", 8'(r), 8'd1);

        // exhaustive sweep, checked by the model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b));
                wait_done(10, lat);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
